// File: rtl/coredma_sram_fifo_ctrl.sv
// coredma_sram_fifo_ctrl: pointer/occupancy sequencer for the 4x50 DMA micro-RAM FIFO, feeding a
// 3-entry first-word-fall-through output buffer that hides the 2-cycle registered RAM read.
// Optional LEVEL / OVF_ERR status logic is built only when COREDMA_SRAM_FIFO_STATUS_EN is defined.
module coredma_sram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 50
) (
  input  logic                  CLK,
  input  logic                  SRST_N,
  input  logic                  FLUSH,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RAM_W_EN,
  output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_W_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  output logic                  RAM_R_ADDR_EN,
  output logic                  RAM_R_DATA_EN,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA,
  output logic                  RAM_BLK_EN,
  output logic [ADDR_WIDTH+1:0] LEVEL,
  output logic                  OVF_ERR
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_CLEAR = 2'd2} state_t;

  state_t                r_state, w_state_nxt;
  logic                  w_run, w_clear;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_ram_cnt, w_ram_cnt_nxt;
  logic                  r_rd_addr_vld;   // launch issued last cycle: RAM data register loads now
  logic                  r_rd_data_vld;   // RAM_R_DATA holds a launched word: capture now
  logic [DATA_WIDTH-1:0] r_buf [3];
  logic [DATA_WIDTH-1:0] w_buf [3];
  logic [1:0]            r_out_cnt, w_out_cnt_nxt;
  logic                  r_blk_en;
  logic [1:0]            w_inflight;
  logic                  w_wr_ready, w_push, w_launch, w_capture, w_rd_valid, w_pop;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!SRST_N) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: flush drains the read pipeline, then clears for one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (FLUSH) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_inflight == 2'd0) w_state_nxt = ST_CLEAR;
      ST_CLEAR: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_run   = (r_state == ST_RUN);
    w_clear = (r_state == ST_CLEAR);
  end

  // Launch budget uses only registered counts, so RD_READY never reaches RAM_R_ADDR_EN.
  assign w_inflight = {1'b0, r_rd_addr_vld} + {1'b0, r_rd_data_vld};
  assign w_wr_ready = SRST_N & w_run & (r_ram_cnt < DEPTH);
  assign w_push     = WR_VALID & w_wr_ready;
  assign w_launch   = SRST_N & w_run & (r_ram_cnt != '0) &
                      (({1'b0, r_out_cnt} + {1'b0, w_inflight}) < 3'd3);
  assign w_capture  = w_run & r_rd_data_vld;
  assign w_rd_valid = w_run & (r_out_cnt != 2'd0);
  assign w_pop      = w_rd_valid & RD_READY;

  assign WR_READY      = w_wr_ready;
  assign RAM_W_EN      = w_push;
  assign RAM_W_ADDR    = r_wr_ptr;
  assign RAM_W_DATA    = WR_DATA;
  assign RAM_R_ADDR    = r_rd_ptr;
  assign RAM_R_ADDR_EN = w_launch;
  assign RAM_R_DATA_EN = r_rd_addr_vld;
  assign RAM_BLK_EN    = r_blk_en;
  assign RD_VALID      = w_rd_valid;
  assign RD_DATA       = r_buf[0];

  // RAM word count: words written in an earlier cycle minus words launched
  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt + CW'(w_push) - CW'(w_launch);
    if (w_clear) w_ram_cnt_nxt = '0;
  end

  // RAM pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!SRST_N || w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_launch) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
    end
    if (!SRST_N) r_ram_cnt <= '0;
    else         r_ram_cnt <= w_ram_cnt_nxt;
  end

  // Read pipeline tracking; reset drops any word still travelling through the RAM
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      r_rd_addr_vld <= 1'b0;
      r_rd_data_vld <= 1'b0;
      r_blk_en      <= 1'b0;
    end else begin
      r_rd_addr_vld <= w_launch;
      r_rd_data_vld <= r_rd_addr_vld;
      r_blk_en      <= 1'b1;
    end
  end

  // Output buffer next value: pop shifts down first, then the captured word lands behind survivors
  always_comb begin
    w_buf         = r_buf;
    w_out_cnt_nxt = r_out_cnt;
    if (w_pop) begin
      w_buf[0]      = r_buf[1];
      w_buf[1]      = r_buf[2];
      w_out_cnt_nxt = r_out_cnt - 2'd1;
    end
    if (w_capture) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) == w_out_cnt_nxt) w_buf[i] = RAM_R_DATA;
      end
      w_out_cnt_nxt = w_out_cnt_nxt + 2'd1;
    end
    if (w_clear) w_out_cnt_nxt = 2'd0;
  end

  // Output buffer registers
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      r_buf     <= '{default: '0};
      r_out_cnt <= 2'd0;
    end else begin
      r_buf     <= w_buf;
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

`ifdef COREDMA_SRAM_FIFO_STATUS_EN
  localparam int LW = ADDR_WIDTH + 2;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  // Status: registered total occupancy and sticky push-while-full flag
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_level <= LW'(w_ram_cnt_nxt) + LW'(w_out_cnt_nxt) +
                 LW'({1'b0, w_launch} + {1'b0, r_rd_addr_vld});
      if (w_clear)                                r_ovf <= 1'b0;
      else if (w_run && WR_VALID && !w_wr_ready)  r_ovf <= 1'b1;
    end
  end

  assign LEVEL   = r_level;
  assign OVF_ERR = r_ovf;
`else
  assign LEVEL   = '0;
  assign OVF_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_coredma_sram_fifo_ctrl.sv
// Bench for coredma_sram_fifo_ctrl: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_coredma_sram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 50;

  logic          CLK = 1'b0;
  logic          SRST_N = 1'b0;
  logic          FLUSH = 1'b0;
  logic          WR_VALID = 1'b0;
  logic          RD_READY = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          WR_READY, RD_VALID, RAM_W_EN, RAM_R_ADDR_EN, RAM_R_DATA_EN, RAM_BLK_EN, OVF_ERR;
  logic [DW-1:0] RD_DATA, RAM_W_DATA, RAM_R_DATA;
  logic [AW-1:0] RAM_W_ADDR, RAM_R_ADDR;
  logic [AW+1:0] LEVEL;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  coredma_sram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .SRST_N(SRST_N), .FLUSH(FLUSH),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
    .RAM_W_EN(RAM_W_EN), .RAM_W_ADDR(RAM_W_ADDR), .RAM_W_DATA(RAM_W_DATA),
    .RAM_R_ADDR(RAM_R_ADDR), .RAM_R_ADDR_EN(RAM_R_ADDR_EN), .RAM_R_DATA_EN(RAM_R_DATA_EN),
    .RAM_R_DATA(RAM_R_DATA), .RAM_BLK_EN(RAM_BLK_EN), .LEVEL(LEVEL), .OVF_ERR(OVF_ERR)
  );

  // 4x50 RAM with address register and data register
  logic [DW-1:0] mem [0:3];
  logic [AW-1:0] ram_addr_q = '0;
  logic [DW-1:0] ram_dat_q  = '0;
  always @(posedge CLK) begin
    if (RAM_W_EN)      mem[RAM_W_ADDR] <= RAM_W_DATA;
    if (RAM_R_ADDR_EN) ram_addr_q <= RAM_R_ADDR;
    if (RAM_R_DATA_EN) ram_dat_q <= mem[ram_addr_q];
  end
  assign RAM_R_DATA = ram_dat_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mst: 0 = running, 1 = draining the read pipeline, 2 = clearing
  int            mst = 0;
  bit            m_on = 0, m_blk = 0, m_ovf = 0, m_prevl = 0;
  int            m_wcnt = 0, m_rcnt = 0;
  logic [DW-1:0] q_ram[$];
  logic [DW-1:0] q_out[$];
  logic [DW-1:0] q_pipe[$];
  int            q_age[$];

  always @(negedge CLK) begin : model
    bit run, e_wr_ready, e_launch, e_rd_valid, push, pop, cap;
    int infl, lvl;
    logic [DW-1:0] d;
    if (!SRST_N) begin
      chk("rst_wr_ready", 64'(WR_READY), 64'd0);
      chk("rst_w_en", 64'(RAM_W_EN), 64'd0);
      chk("rst_r_addr_en", 64'(RAM_R_ADDR_EN), 64'd0);
      if (m_on) chk("rst_blk_en", 64'(RAM_BLK_EN), 64'(m_blk));
      mst = 0; m_blk = 0; m_ovf = 0; m_prevl = 0; m_wcnt = 0; m_rcnt = 0;
      q_ram.delete(); q_out.delete(); q_pipe.delete(); q_age.delete();
      m_on = 1;
    end else if (m_on) begin
      run        = (mst == 0);
      infl       = q_pipe.size();
      e_wr_ready = run && (q_ram.size() < 4);
      e_launch   = run && (q_ram.size() > 0) && (q_out.size() + infl < 3);
      e_rd_valid = run && (q_out.size() > 0);
      lvl        = q_ram.size() + infl + q_out.size();
      chk("wr_ready", 64'(WR_READY), 64'(e_wr_ready));
      chk("ram_w_en", 64'(RAM_W_EN), 64'(WR_VALID && e_wr_ready));
      chk("ram_w_addr", 64'(RAM_W_ADDR), 64'(m_wcnt % 4));
      chk("ram_w_data", 64'(RAM_W_DATA), 64'(WR_DATA));
      chk("ram_r_addr", 64'(RAM_R_ADDR), 64'(m_rcnt % 4));
      chk("ram_r_addr_en", 64'(RAM_R_ADDR_EN), 64'(e_launch));
      chk("ram_r_data_en", 64'(RAM_R_DATA_EN), 64'(m_prevl));
      chk("rd_valid", 64'(RD_VALID), 64'(e_rd_valid));
      if (e_rd_valid) chk("rd_data", 64'(RD_DATA), 64'(q_out[0]));
      chk("blk_en", 64'(RAM_BLK_EN), 64'(m_blk));
`ifdef COREDMA_SRAM_FIFO_STATUS_EN
      chk("level", 64'(LEVEL), 64'(lvl));
      chk("ovf_err", 64'(OVF_ERR), 64'(m_ovf));
`else
      chk("level", 64'(LEVEL), 64'd0);
      chk("ovf_err", 64'(OVF_ERR), 64'd0);
`endif
      // advance the model across the coming edge
      push = WR_VALID && e_wr_ready;
      pop  = e_rd_valid && RD_READY;
      cap  = (q_age.size() > 0) && (q_age[0] == 1);
      if (run && WR_VALID && !e_wr_ready) m_ovf = 1;
      if (pop) void'(q_out.pop_front());
      if (cap) begin
        d = q_pipe.pop_front();
        void'(q_age.pop_front());
        if (run) q_out.push_back(d);
      end
      foreach (q_age[i]) q_age[i] = q_age[i] - 1;
      if (e_launch) begin
        q_pipe.push_back(q_ram.pop_front());
        q_age.push_back(2);
        m_rcnt++;
      end
      if (push) begin
        q_ram.push_back(WR_DATA);
        m_wcnt++;
      end
      m_prevl = e_launch;
      m_blk   = 1;
      if (mst == 0 && FLUSH) mst = 1;
      else if (mst == 1 && infl == 0) mst = 2;
      else if (mst == 2) begin
        q_ram.delete(); q_out.delete();
        m_wcnt = 0; m_rcnt = 0; m_ovf = 0; mst = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    SRST_N = 0; FLUSH = 0; WR_VALID = 0; RD_READY = 0;
    repeat (2) step();
    SRST_N = 1;
  endtask

  task automatic stream(input int n, input int base, input bit toggle);
    int k, got, cyc;
    bit acc, popd;
    logic [DW-1:0] pd;
    k = 0; got = 0; cyc = 0;
    WR_VALID = 1; WR_DATA = DW'(base); RD_READY = 1;
    while (got < n && cyc < 400) begin
      @(negedge CLK);
      acc  = WR_VALID && WR_READY;
      popd = RD_VALID && RD_READY;
      pd   = RD_DATA;
      step();
      if (acc) begin
        k++;
        WR_DATA = DW'(base + k);
        if (k >= n) WR_VALID = 0;
      end
      if (popd) begin
        chk("stream_order", 64'(pd), 64'(base + got));
        got++;
      end
      if (toggle) RD_READY = ~RD_READY;
      cyc++;
    end
    chk("stream_count", 64'(got), 64'(n));
    WR_VALID = 0; RD_READY = 0;
  endtask

  initial begin : stim
    int fill_cnt;
    // reset values
    SRST_N = 0;
    repeat (3) step();
    @(negedge CLK);
    chk("reset_rd_valid", 64'(RD_VALID), 64'd0);
    chk("reset_blk_en", 64'(RAM_BLK_EN), 64'd0);
    chk("reset_r_data_en", 64'(RAM_R_DATA_EN), 64'd0);
    chk("reset_level", 64'(LEVEL), 64'd0);
    chk("reset_ovf", 64'(OVF_ERR), 64'd0);
    step();
    // first word: push at edge 1, launch at edge 2, visible after edge 4
    SRST_N = 1; WR_VALID = 1; WR_DATA = DW'(1); RD_READY = 0;
    @(negedge CLK);
    chk("first_w_en", 64'(RAM_W_EN), 64'd1);
    chk("first_w_addr", 64'(RAM_W_ADDR), 64'd0);
    step(); WR_VALID = 0;
    @(negedge CLK);
    chk("first_launch", 64'(RAM_R_ADDR_EN), 64'd1);
    chk("first_blk_en", 64'(RAM_BLK_EN), 64'd1);
    step();
    @(negedge CLK);
    chk("first_data_en", 64'(RAM_R_DATA_EN), 64'd1);
    chk("first_rd_valid_e2", 64'(RD_VALID), 64'd0);
    step();
    @(negedge CLK);
    chk("first_rd_valid_e3", 64'(RD_VALID), 64'd0);
    step();
    @(negedge CLK);
    chk("first_rd_valid_e4", 64'(RD_VALID), 64'd1);
    chk("first_rd_data", 64'(RD_DATA), 64'd1);
    step();

    // fill with the consumer stalled: 7 words fit
    do_reset();
    WR_VALID = 1; fill_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      WR_DATA = DW'(300 + fill_cnt);
      @(negedge CLK);
      if (RAM_W_EN) fill_cnt++;
      step();
    end
    @(negedge CLK);
    chk("fill_count", 64'(fill_cnt), 64'd7);
    chk("fill_wr_ready", 64'(WR_READY), 64'd0);
`ifdef COREDMA_SRAM_FIFO_STATUS_EN
    chk("fill_level", 64'(LEVEL), 64'd7);
    chk("fill_ovf", 64'(OVF_ERR), 64'd1);
`else
    chk("fill_level", 64'(LEVEL), 64'd0);
    chk("fill_ovf", 64'(OVF_ERR), 64'd0);
`endif
    step();
    WR_VALID = 0;
    // pop twice so reads are in flight, then flush
    RD_READY = 1;
    repeat (2) step();
    RD_READY = 0; FLUSH = 1;
    step();
    FLUSH = 0;
    @(negedge CLK);
    chk("flush_drain_wr_ready", 64'(WR_READY), 64'd0);
    chk("flush_drain_rd_valid", 64'(RD_VALID), 64'd0);
    repeat (5) step();
    @(negedge CLK);
    chk("flush_rd_valid", 64'(RD_VALID), 64'd0);
    chk("flush_wr_ready", 64'(WR_READY), 64'd1);
    chk("flush_level", 64'(LEVEL), 64'd0);
    chk("flush_ovf", 64'(OVF_ERR), 64'd0);
    step();

    // continuous stream and a stream with a toggling consumer
    stream(20, 100, 1'b0);
    stream(10, 200, 1'b1);
    repeat (6) step();

    // reset one cycle after a launch: stale RAM data must never surface
    do_reset();
    WR_VALID = 1; WR_DATA = DW'(77);
    step();
    WR_VALID = 0;
    @(negedge CLK);
    chk("ral_launch", 64'(RAM_R_ADDR_EN), 64'd1);
    step();
    SRST_N = 0;
    step();
    SRST_N = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("ral_rd_valid", 64'(RD_VALID), 64'd0);
      step();
    end

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 2000; i++) begin
      SRST_N   = ($urandom_range(0, 199) != 0);
      FLUSH    = ($urandom_range(0, 39) == 0);
      WR_VALID = ($urandom_range(0, 9) < 7);
      RD_READY = ($urandom_range(0, 9) < 6);
      WR_DATA  = DW'({$urandom(), $urandom()});
      step();
    end
    SRST_N = 1; FLUSH = 0; WR_VALID = 0; RD_READY = 1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
